// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        ARMED
    } state_e;

    // Widest pattern the mask helper can describe.
    localparam int unsigned MASK_MAX_W = 64;

    function automatic int unsigned len_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Low `len` bits set; callers truncate to their own pattern width.
    function automatic logic [MASK_MAX_W-1:0] len_mask(input int unsigned len);
        logic [MASK_MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_det_if.sv
// Detector bus: serial input, pattern configuration and match outputs.
interface seq_det_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = len_w(PAT_W)
);
    logic             x_valid;
    logic             x;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic [LEN_W-1:0] pat_len;
    logic             overlap;
    logic             cnt_clr;
    logic             y;
    logic             armed;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output x_valid, x, pat_load, pat_in, pat_len, overlap, cnt_clr,
        input  y, armed, match_cnt
    );

    modport slave (
        input  x_valid, x, pat_load, pat_in, pat_len, overlap, cnt_clr,
        output y, armed, match_cnt
    );
endinterface

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial bit-sequence detector with overlap control and match counter.
// Build option: define SEQ_DET_MOORE_EN for a registered (Moore) y output; default is Mealy.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input logic     clk,
    input logic     rst,
    seq_det_if.slave bus
);
    localparam int LEN_W = len_w(PAT_W);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    state_e           state_q, state_d;

    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] hist_next;
    logic [LEN_W:0]   fill_inc;
    logic             consume;
    logic             match;

    // A bit offered in a load cycle is discarded, so load masks consumption.
    always_comb begin
        mask      = PAT_W'(len_mask(32'(len_q)));
        hist_next = {hist_q[PAT_W-2:0], bus.x};
        fill_inc  = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
        consume   = bus.x_valid && !bus.pat_load && !rst;
        match     = consume && (len_q != '0) && (fill_inc >= {1'b0, len_q})
                    && ((hist_next & mask) == (pattern_q & mask));
    end

    always_comb begin
        hist_d    = hist_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        fill_d    = fill_q;
        state_d   = state_q;

        if (bus.pat_load) begin
            pattern_d = bus.pat_in;
            len_d     = (bus.pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.pat_len;
            hist_d    = '0;
            fill_d    = '0;
        end else if (consume) begin
            hist_d = hist_next;
            if (match && !bus.overlap) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(PAT_W)) begin
                fill_d = fill_inc[LEN_W-1:0];
            end
        end

        if (fill_d == '0) begin
            state_d = EMPTY;
        end else if ((len_d != '0) && (fill_d >= len_d)) begin
            state_d = ARMED;
        end else begin
            state_d = FILLING;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            fill_q    <= '0;
            state_q   <= EMPTY;
        end else begin
            hist_q    <= hist_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
        end
    end

    assign bus.armed = (state_q == ARMED);

    seq_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (match),
        .clr_i (bus.cnt_clr),
        .cnt_o (bus.match_cnt)
    );

`ifdef SEQ_DET_MOORE_EN
    logic y_q;

    always_ff @(posedge clk) begin
        if (rst || bus.pat_load) y_q <= 1'b0;
        else                     y_q <= match;
    end

    assign bus.y = y_q;
`else
    assign bus.y = match;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; y is sampled per build (Mealy pre-edge, Moore post-edge).
module tb_seq_detector_param;
    import seq_det_pkg::*;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;
    localparam int LEN_W = len_w(PAT_W);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_det_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_a ();
    seq_det_if #(.PAT_W(PAT_W), .CNT_W(2))     bus_b ();

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave)
    );
    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(2)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );

    // The narrow-counter instance sees exactly the same stimulus.
    assign bus_b.x_valid  = bus_a.x_valid;
    assign bus_b.x        = bus_a.x;
    assign bus_b.pat_load = bus_a.pat_load;
    assign bus_b.pat_in   = bus_a.pat_in;
    assign bus_b.pat_len  = bus_a.pat_len;
    assign bus_b.overlap  = bus_a.overlap;
    assign bus_b.cnt_clr  = bus_a.cnt_clr;

    int compared   = 0;
    int mismatched = 0;

    // One consumed/idle cycle; y sampled where the build defines it, armed after the edge.
    task automatic step(input logic v, input logic b, output logic y_obs, output logic armed_obs);
        @(negedge clk);
        bus_a.x_valid = v;
        bus_a.x       = b;
        #1;
`ifndef SEQ_DET_MOORE_EN
        y_obs = bus_a.y;
`endif
        @(posedge clk);
        #1;
`ifdef SEQ_DET_MOORE_EN
        y_obs = bus_a.y;
`endif
        armed_obs     = bus_a.armed;
        bus_a.cnt_clr = 1'b0;
    endtask

    task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len, input logic ov);
        @(negedge clk);
        bus_a.pat_load = 1'b1;
        bus_a.pat_in   = pat;
        bus_a.pat_len  = len;
        bus_a.overlap  = ov;
        bus_a.x_valid  = 1'b0;
        @(posedge clk);
        #1;
        bus_a.pat_load = 1'b0;
    endtask

    task automatic clear_cnt();
        @(negedge clk);
        bus_a.cnt_clr = 1'b1;
        bus_a.x_valid = 1'b0;
        @(posedge clk);
        #1;
        bus_a.cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus_a.x_valid = 1'b1;
            bus_a.x       = i[0];
            @(posedge clk);
            #1;
            compared += 3;
            if (bus_a.y !== 1'b0) begin
                mismatched++; $display("FAIL reset_y[%0d]: got %b want 0", i, bus_a.y);
            end
            if (bus_a.armed !== 1'b0) begin
                mismatched++; $display("FAIL reset_armed[%0d]: got %b want 0", i, bus_a.armed);
            end
            if (bus_a.match_cnt !== 8'd0) begin
                mismatched++; $display("FAIL reset_cnt[%0d]: got %0d want 0", i, bus_a.match_cnt);
            end
        end
        rst = 1'b0;
        bus_a.x_valid = 1'b0;
    endtask

    // Stream 1,0,1,1,0,1,1 against 1011: bits 4 and 7 match when overlapping.
    task automatic test_overlap();
        logic [6:0] bits  = 7'b1011011;
        logic [6:0] exp_y = 7'b0001001;
        logic [6:0] exp_a = 7'b0001111;
        logic y_o, a_o;
        load(8'b1011, 4'd4, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[6-i], y_o, a_o);
            compared += 2;
            if (y_o !== exp_y[6-i]) begin
                mismatched++; $display("FAIL ovl_y bit%0d: got %b want %b", i + 1, y_o, exp_y[6-i]);
            end
            if (a_o !== exp_a[6-i]) begin
                mismatched++; $display("FAIL ovl_armed bit%0d: got %b want %b", i + 1, a_o, exp_a[6-i]);
            end
        end
        compared++;
        if (bus_a.match_cnt !== 8'd2) begin
            mismatched++; $display("FAIL ovl_cnt: got %0d want 2", bus_a.match_cnt);
        end
    endtask

    task automatic test_non_overlap();
        logic [6:0] bits  = 7'b1011011;
        logic [6:0] exp_y = 7'b0001000;
        logic y_o, a_o;
        load(8'b1011, 4'd4, 1'b0);
        clear_cnt();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[6-i], y_o, a_o);
            compared += 2;
            if (y_o !== exp_y[6-i]) begin
                mismatched++; $display("FAIL novl_y bit%0d: got %b want %b", i + 1, y_o, exp_y[6-i]);
            end
            if (a_o !== 1'b0) begin
                mismatched++; $display("FAIL novl_armed bit%0d: got %b want 0", i + 1, a_o);
            end
        end
        compared++;
        if (bus_a.match_cnt !== 8'd1) begin
            mismatched++; $display("FAIL novl_cnt: got %0d want 1", bus_a.match_cnt);
        end
    endtask

    task automatic test_idle_gaps();
        logic [6:0] bits  = 7'b1011011;
        logic [6:0] exp_y = 7'b0001001;
        logic y_o, a_o;
        load(8'b1011, 4'd4, 1'b1);
        clear_cnt();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[6-i], y_o, a_o);
            compared++;
            if (y_o !== exp_y[6-i]) begin
                mismatched++; $display("FAIL idle_y bit%0d: got %b want %b", i + 1, y_o, exp_y[6-i]);
            end
            step(1'b0, ~bits[6-i], y_o, a_o);
            compared++;
            if (y_o !== 1'b0) begin
                mismatched++; $display("FAIL idle_gap_y after bit%0d: got %b want 0", i + 1, y_o);
            end
        end
        compared++;
        if (bus_a.match_cnt !== 8'd2) begin
            mismatched++; $display("FAIL idle_cnt: got %0d want 2", bus_a.match_cnt);
        end
    endtask

    // Reload mid-stream: the bit offered with pat_load is dropped, count is kept.
    task automatic test_reload();
        logic [2:0] pre   = 3'b101;
        logic [2:0] bits  = 3'b110;
        logic [2:0] exp_y = 3'b001;
        logic [2:0] exp_a = 3'b001;
        logic y_o, a_o;
        load(8'b1011, 4'd4, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, pre[2-i], y_o, a_o);
        @(negedge clk);
        bus_a.pat_load = 1'b1;
        bus_a.pat_in   = 8'b110;
        bus_a.pat_len  = 4'd3;
        bus_a.x_valid  = 1'b1;
        bus_a.x        = 1'b1;
        #1;
`ifndef SEQ_DET_MOORE_EN
        y_o = bus_a.y;
`endif
        @(posedge clk);
        #1;
`ifdef SEQ_DET_MOORE_EN
        y_o = bus_a.y;
`endif
        bus_a.pat_load = 1'b0;
        compared += 3;
        if (y_o !== 1'b0) begin
            mismatched++; $display("FAIL reload_y: got %b want 0", y_o);
        end
        if (bus_a.armed !== 1'b0) begin
            mismatched++; $display("FAIL reload_armed: got %b want 0", bus_a.armed);
        end
        if (bus_a.match_cnt !== 8'd2) begin
            mismatched++; $display("FAIL reload_cnt_kept: got %0d want 2", bus_a.match_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, bits[2-i], y_o, a_o);
            compared += 2;
            if (y_o !== exp_y[2-i]) begin
                mismatched++; $display("FAIL reload_y bit%0d: got %b want %b", i + 1, y_o, exp_y[2-i]);
            end
            if (a_o !== exp_a[2-i]) begin
                mismatched++; $display("FAIL reload_armed bit%0d: got %b want %b", i + 1, a_o, exp_a[2-i]);
            end
        end
    endtask

    // Five overlapping matches: 2-bit counter pins at 3; clear beats a sixth match.
    task automatic test_saturation();
        logic [15:0] bits = 16'b1011011011011011;
        logic [2:0]  tail = 3'b011;
        logic y_o, a_o;
        logic exp;
        load(8'b1011, 4'd4, 1'b1);
        clear_cnt();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, bits[15-i], y_o, a_o);
            exp = (i >= 3) && ((i % 3) == 0);
            compared++;
            if (y_o !== exp) begin
                mismatched++; $display("FAIL sat_y bit%0d: got %b want %b", i + 1, y_o, exp);
            end
        end
        compared += 2;
        if (bus_b.match_cnt !== 2'd3) begin
            mismatched++; $display("FAIL sat_cnt_w2: got %0d want 3", bus_b.match_cnt);
        end
        if (bus_a.match_cnt !== 8'd5) begin
            mismatched++; $display("FAIL sat_cnt_w8: got %0d want 5", bus_a.match_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus_a.cnt_clr = 1'b1;
            step(1'b1, tail[2-i], y_o, a_o);
        end
        compared += 3;
        if (y_o !== 1'b1) begin
            mismatched++; $display("FAIL clr_match_y: got %b want 1", y_o);
        end
        if (bus_b.match_cnt !== 2'd0) begin
            mismatched++; $display("FAIL clr_wins_w2: got %0d want 0", bus_b.match_cnt);
        end
        if (bus_a.match_cnt !== 8'd0) begin
            mismatched++; $display("FAIL clr_wins_w8: got %0d want 0", bus_a.match_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic y_o, a_o;
        step(1'b1, 1'b0, y_o, a_o);
        step(1'b1, 1'b1, y_o, a_o);
        @(negedge clk);
        rst           = 1'b1;
        bus_a.x_valid = 1'b1;
        bus_a.x       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Detector is disabled (len=0) after reset, so this would-be match must not fire.
        step(1'b1, 1'b1, y_o, a_o);
        compared += 3;
        if (y_o !== 1'b0) begin
            mismatched++; $display("FAIL midrst_y: got %b want 0", y_o);
        end
        if (a_o !== 1'b0) begin
            mismatched++; $display("FAIL midrst_armed: got %b want 0", a_o);
        end
        if (bus_a.match_cnt !== 8'd0) begin
            mismatched++; $display("FAIL midrst_cnt: got %0d want 0", bus_a.match_cnt);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus_a.x_valid  = 1'b0;
        bus_a.x        = 1'b0;
        bus_a.pat_load = 1'b0;
        bus_a.pat_in   = '0;
        bus_a.pat_len  = '0;
        bus_a.overlap  = 1'b0;
        bus_a.cnt_clr  = 1'b0;

        test_reset();
        test_overlap();
        test_non_overlap();
        test_idle_gaps();
        test_reload();
        test_saturation();
        test_mid_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
